cic_decimator_core: RTL
=======================

Name: cic_decimator_core

Overview:
Multi-stage CIC decimator: a pipelined integrator chain, a decimation phase counter, and a pipelined comb chain. It consumes 16-bit signed samples with a valid strobe. It produces full-precision ACC_WIDTH accumulator words plus valid_out, which go directly to the rounding/overflow stage; that stage handles gain scaling, rounding and saturation. No internal truncation or saturation.

Parameters:
IN_WIDTH, 16, signed input sample width
ACC_WIDTH, 42, internal/output width; must be >= IN_WIDTH + N_STAGES*clog2(DEC_MAX)
N_STAGES, 5, number of integrator and comb stages (N); differential delay M fixed at 1
DEC_MAX, 32, largest supported decimation factor R
DEC_W, $clog2(DEC_MAX+1), width of dec_factor (6 at default)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
clear  in  1  synchronous flush of all datapath state (filter restart)
dec_factor  in  DEC_W  requested decimation factor R, legal 1..DEC_MAX
data_in  in  IN_WIDTH  signed input sample
valid_in  in  1  data_in valid; may be high every cycle
data_out  out  ACC_WIDTH  signed decimated full-precision output
valid_out  out  1  one-cycle strobe per decimated sample
cfg_err  out  1  sticky flag: an illegal dec_factor was latched

Behaviour:
- Reset (rst_n=0 at clk edge): all integrators, comb delays, comb outputs, phase counter, strobe pipe = 0. data_out=0, valid_out=0, cfg_err=0. R_active = sanitised dec_factor.
- Priority per edge: rst_n > clear > normal operation. clear zeroes integrators, combs, counter, strobe pipe, data_out and valid_out, and re-latches R_active. cfg_err is also cleared. In-flight samples are dropped.
- Integrators update only on valid_in=1; otherwise they hold.
  - int[0] <= int[0] + sext(data_in).
  - int[k] <= int[k] + int[k-1] (old value, one register per stage).
- All adds/subtracts are ACC_WIDTH two's-complement modulo. Integrator wrap-around is intended and must not be detected or saturated.
- Phase counter cnt counts valid_in samples 0..R_active-1.
  - A valid_in with cnt==R_active-1 sets cnt to 0 and fires dec_strobe.
  - In the same edge, int[N-1] (value before that edge's update) is captured into the comb input register.
- Combs are one register per stage and advance only on their strobe:
  - comb[j] <= x[j] - dly[j]; dly[j] <= x[j].
  - x[0] is the captured sample; x[j] = comb[j-1].
- Latency: dec_strobe is issued by the frame-closing valid_in in cycle t. valid_out is high in cycle t+N_STAGES+1 for exactly one cycle, with data_out = comb[N-1].
- data_out holds its last value while valid_out=0.
- Throughput: R_active=1 with continuous valid_in gives continuous valid_out, with no bubbles and no stall.
- dec_factor sanitising: values 0 or >DEC_MAX are latched as DEC_MAX and set cfg_err.
- dec_factor latching: R_active is re-latched only at reset, at clear, and at the edge that fires dec_strobe, so a change takes effect at the next frame boundary. A change mid-frame never shortens or extends the current frame.
- Startup transient: the first N_STAGES valid_out samples after reset/clear are filter fill and are not guaranteed to be steady-state.
- Steady-state DC gain = R_active^N_STAGES (e.g. R=32, N=5 gives 2^25).

Decomposition:
- Package cic_pkg holds:
  - default constants: IN_WIDTH, ACC_WIDTH, N_STAGES, DEC_MAX;
  - the function computing required growth bits, N*clog2(R);
  - a typedef for the signed ACC_WIDTH accumulator word, shared with the rounding stage.
- Sub-module cic_comb_stage: a single registered differentiator (x, strobe in; y, strobe out; clear). It is instantiated N_STAGES times via generate.
- The integrator chain stays inline.
- Elaboration-time check: ACC_WIDTH >= IN_WIDTH + N_STAGES*clog2(DEC_MAX).

Test Plan:
- DC gain: R=4, data_in=1 continuous. After 5 fill outputs, every data_out = 1024; valid_out period = 4 cycles; latency = 6 cycles from the frame-closing input.
- Full-scale wrap: R=32, data_in=-32768 continuous for 400 samples. Integrators wrap repeatedly; steady-state data_out = -2^40 exactly with no corruption. Repeat with +32767 and expect 32767*2^25.
- Gapped valid: R=8, data_in=100, valid_in high 1 cycle in 3. Steady data_out = 100*8^5 = 3,276,800; valid_out every 24 cycles; integrators hold during gaps.
- Rate change: R=4 running, dec_factor changed to 8 mid-frame. The current frame still closes after 4 samples, then the frame length becomes 8; DC output settles to x*32768 after 5 outputs.
- Illegal config: dec_factor=0 and then 40 latched. cfg_err=1; behaviour matches R=32. A clear pulse drops cfg_err to 0, zeroes data_out, and gives no valid_out for the next N_STAGES+1 cycles.
- Reset mid-operation: rst_n low for 1 cycle while a strobe is in the comb pipe. valid_out never fires for that in-flight sample; all outputs are 0 in the following cycle.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared constants, growth-bit helper and accumulator word type for the CIC
// decimator and its downstream rounding/overflow stage.
package cic_pkg;

    localparam int CIC_IN_WIDTH  = 16;
    localparam int CIC_ACC_WIDTH = 42;
    localparam int CIC_N_STAGES  = 5;
    localparam int CIC_DEC_MAX   = 32;

    typedef logic signed [CIC_ACC_WIDTH-1:0] cic_acc_t;

    // Worst-case word growth of an N-stage, M=1 CIC at decimation factor r.
    function automatic int cic_growth_bits(input int n, input int r);
        return n * $clog2(r);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC differentiator (M=1): advances only when its strobe is
// high, and forwards the strobe with one cycle of delay.
module cic_comb_stage #(
    parameter int W = 42
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [W-1:0] x,
    input  logic         strobe_in,
    output logic [W-1:0] y,
    output logic         strobe_out
);

    logic [W-1:0] dly;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            dly        <= '0;
            y          <= '0;
            strobe_out <= 1'b0;
        end else begin
            strobe_out <= strobe_in;
            if (strobe_in) begin
                y   <= x - dly;
                dly <= x;
            end
        end
    end

endmodule

// File: rtl/cic_decimator_core.sv
// N-stage CIC decimator: pipelined integrators, frame counter with a
// frame-boundary rate latch, and a strobe-driven comb chain at full precision.
module cic_decimator_core
    import cic_pkg::*;
#(
    parameter int IN_WIDTH  = CIC_IN_WIDTH,
    parameter int ACC_WIDTH = CIC_ACC_WIDTH,
    parameter int N_STAGES  = CIC_N_STAGES,
    parameter int DEC_MAX   = CIC_DEC_MAX,
    parameter int DEC_W     = $clog2(DEC_MAX + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic [DEC_W-1:0]            dec_factor,
    input  logic signed [IN_WIDTH-1:0]  data_in,
    input  logic                        valid_in,
    output logic signed [ACC_WIDTH-1:0] data_out,
    output logic                        valid_out,
    output logic                        cfg_err
);

    localparam int GROWTH = cic_growth_bits(N_STAGES, DEC_MAX);

    if (ACC_WIDTH < IN_WIDTH + GROWTH) begin : g_width_check
        $error("cic_decimator_core: ACC_WIDTH too small for N_STAGES/DEC_MAX");
    end

    logic [N_STAGES-1:0][ACC_WIDTH-1:0] integ;
    logic [ACC_WIDTH-1:0]               in_ext;
    logic [DEC_W-1:0]                   r_active;
    logic [DEC_W-1:0]                   cnt;
    logic [DEC_W-1:0]                   r_next;
    logic                               dec_bad;
    logic                               dec_strobe;
    logic [ACC_WIDTH-1:0]               cap;
    logic                               cap_vld;

    assign in_ext = {{(ACC_WIDTH-IN_WIDTH){data_in[IN_WIDTH-1]}}, data_in};

    // Out-of-range factors fall back to the slowest legal rate.
    assign dec_bad    = (dec_factor == '0) || (dec_factor > DEC_W'(DEC_MAX));
    assign r_next     = dec_bad ? DEC_W'(DEC_MAX) : dec_factor;
    assign dec_strobe = valid_in && (cnt == r_active - DEC_W'(1));

    // Integrators wrap modulo 2^ACC_WIDTH by design; the combs undo the wrap.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            integ <= '0;
        end else if (valid_in) begin
            integ[0] <= integ[0] + in_ext;
            for (int k = 1; k < N_STAGES; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt      <= '0;
            r_active <= r_next;
            cfg_err  <= 1'b0;
            cap      <= '0;
            cap_vld  <= 1'b0;
        end else begin
            cap_vld <= dec_strobe;
            if (dec_strobe) begin
                cnt      <= '0;
                r_active <= r_next;
                cfg_err  <= cfg_err | dec_bad;
                cap      <= integ[N_STAGES-1];
            end else if (valid_in) begin
                cnt <= cnt + DEC_W'(1);
            end
        end
    end

    logic [N_STAGES:0][ACC_WIDTH-1:0] comb_x;
    logic [N_STAGES:0]                comb_s;

    assign comb_x[0] = cap;
    assign comb_s[0] = cap_vld;

    for (genvar j = 0; j < N_STAGES; j++) begin : g_comb
        cic_comb_stage #(.W(ACC_WIDTH)) u_comb (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (clear),
            .x          (comb_x[j]),
            .strobe_in  (comb_s[j]),
            .y          (comb_x[j+1]),
            .strobe_out (comb_s[j+1])
        );
    end

    assign data_out  = comb_x[N_STAGES];
    assign valid_out = comb_s[N_STAGES];

endmodule
